// File: rtl/flash_pkg.sv
// -----------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the SPI NOR flash burst read engine: default
// parameters, instruction codes, request mode encodings and FSM states.
// -----------------------------------------------------------------------------
package flash_pkg;

    localparam int SCLK_DIV_DEF  = 4;   // mclk cycles per sclk period
    localparam int ADDR_NBIT_DEF = 24;  // flash address width
    localparam int LEN_NBIT_DEF  = 8;   // burst length field width
    localparam int DUMMY_CLKS    = 8;   // FAST_READ dummy sclk periods

    localparam logic [7:0] INS_READ      = 8'h03;
    localparam logic [7:0] INS_FAST_READ = 8'h0B;
    localparam logic [7:0] INS_JEDEC_ID  = 8'h9F;

    typedef enum logic [1:0] {
        MODE_READ  = 2'b00,
        MODE_FAST  = 2'b01,
        MODE_JEDEC = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CSSU  = 3'd1,
        ST_INS   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_DATA  = 3'd5,
        ST_CSHD  = 3'd6
    } state_e;

    // Instruction byte sent for a captured mode.
    function automatic logic [7:0] ins_code(input mode_e m);
        case (m)
            MODE_FAST:  return INS_FAST_READ;
            MODE_JEDEC: return INS_JEDEC_ID;
            default:    return INS_READ;
        endcase
    endfunction

endpackage

// File: rtl/flash_sclk_gen.sv
// -----------------------------------------------------------------------------
// flash_sclk_gen
// Serial clock divider. The count runs 0..SCLK_DIV-1 while run_i is high and
// sits at 0 otherwise. sclk is high in the upper half of each period.
//   mclk, rst    main clock, asynchronous active-high reset
//   run_i        transaction active (any state except IDLE)
//   sclk_en_i    phase that toggles sclk (INS, ADDR, DUMMY, DATA)
//   sclk_o       serial clock, SPI mode 0
//   fall_o       last mclk cycle of an sclk period (falling edge follows)
//   sample_o     first mclk cycle with sclk high (sdi sample point)
// -----------------------------------------------------------------------------
module flash_sclk_gen
    import flash_pkg::*;
#(
    parameter int SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic mclk,
    input  logic rst,
    input  logic run_i,
    input  logic sclk_en_i,
    output logic sclk_o,
    output logic fall_o,
    output logic sample_o
);

    localparam int              CW   = $clog2(SCLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0]   HALF = CW'(SCLK_DIV / 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sclk_o   = sclk_en_i && (cnt_q >= HALF);
    assign fall_o   = run_i && (cnt_q == LAST);
    assign sample_o = sclk_en_i && (cnt_q == HALF);

endmodule

// File: rtl/flash_burst_rd.sv
// -----------------------------------------------------------------------------
// flash_burst_rd
// SPI NOR flash burst read engine (READ / FAST_READ / JEDEC ID). Accepts one
// request at a time and streams one byte per rdv pulse.
//   mclk, rst          main clock, asynchronous active-high reset
//   rd, mode, raddr,   request strobe and fields, sampled only when idle
//   rlen               (bytes = rlen+1)
//   rbusy              transaction in progress
//   rdata, rdv         received byte and its one-cycle valid pulse
//   rdone              one-cycle pulse on return to IDLE
//   sclk, cs, sdo, sdi flash serial interface (mode 0, cs active-low)
//   wp, hold           tied inactive high
// -----------------------------------------------------------------------------
module flash_burst_rd
    import flash_pkg::*;
#(
    parameter int SCLK_DIV  = SCLK_DIV_DEF,
    parameter int ADDR_NBIT = ADDR_NBIT_DEF,  // must exceed 8
    parameter int LEN_NBIT  = LEN_NBIT_DEF
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic [1:0]           mode,
    input  logic [ADDR_NBIT-1:0] raddr,
    input  logic [LEN_NBIT-1:0]  rlen,
    output logic                 rbusy,
    output logic [7:0]           rdata,
    output logic                 rdv,
    output logic                 rdone,
    output logic                 sclk,
    output logic                 cs,
    output logic                 sdo,
    input  logic                 sdi,
    output logic                 wp,
    output logic                 hold
);

    localparam int BW = $clog2(ADDR_NBIT);

    state_e                 state_q, state_d;
    mode_e                  mode_q;
    logic [ADDR_NBIT-1:0]   addr_q;
    logic [ADDR_NBIT-1:0]   tx_q;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             rdata_q;
    logic                   rdv_q, rdone_q;
    logic [BW-1:0]          bit_cnt_q, phase_last;
    logic [LEN_NBIT:0]      byte_left_q;  // one extra bit: rlen all-ones gives 2^LEN_NBIT
    logic                   accept, fall, sample, bit_last, shift_phase;

    assign accept      = (state_q == ST_IDLE) && rd;
    assign shift_phase = (state_q == ST_INS) || (state_q == ST_ADDR) ||
                         (state_q == ST_DUMMY) || (state_q == ST_DATA);
    assign bit_last    = (bit_cnt_q == phase_last);

    flash_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
        .mclk      (mclk),
        .rst       (rst),
        .run_i     (state_q != ST_IDLE),
        .sclk_en_i (shift_phase),
        .sclk_o    (sclk),
        .fall_o    (fall),
        .sample_o  (sample)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        phase_last = BW'(7);
        case (state_q)
            ST_IDLE:  if (rd) state_d = ST_CSSU;
            ST_CSSU:  if (fall) state_d = ST_INS;
            ST_INS:   if (fall && bit_last)
                          state_d = (mode_q == MODE_JEDEC) ? ST_DATA : ST_ADDR;
            ST_ADDR: begin
                phase_last = BW'(ADDR_NBIT - 1);
                if (fall && bit_last)
                    state_d = (mode_q == MODE_FAST) ? ST_DUMMY : ST_DATA;
            end
            ST_DUMMY: begin
                phase_last = BW'(DUMMY_CLKS - 1);
                if (fall && bit_last) state_d = ST_DATA;
            end
            ST_DATA:  if (fall && bit_last && byte_left_q == (LEN_NBIT+1)'(1))
                          state_d = ST_CSHD;
            ST_CSHD:  if (fall) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // With SCLK_DIV=2 the 8th sample and the byte hand-off fall in the same
    // cycle, so the byte output takes the post-sample value.
    always_comb begin
        rx_d = rx_q;
        if (sample && state_q == ST_DATA) begin
            rx_d = {rx_q[6:0], sdi};
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: all datapath flops are reset, so an aborted transaction leaves no
    // stale byte on rdata and no half-shifted instruction.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_READ;
            addr_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            rdv_q       <= 1'b0;
            rdone_q     <= 1'b0;
            bit_cnt_q   <= '0;
            byte_left_q <= '0;
        end else begin
            rdv_q   <= 1'b0;
            rdone_q <= 1'b0;
            rx_q    <= rx_d;

            if (accept) begin
                mode_q      <= (mode == MODE_RSVD) ? MODE_READ : mode_e'(mode);
                addr_q      <= raddr;
                byte_left_q <= (LEN_NBIT+1)'(rlen) + 1'b1;
            end

            if (fall) begin
                bit_cnt_q <= (bit_last || !shift_phase) ? '0 : bit_cnt_q + 1'b1;

                // sdo is driven from the MSB; loading at the end of the
                // previous period puts each first bit on the wire before the
                // first rising edge of its phase.
                case (state_q)
                    ST_CSSU: tx_q <= {ins_code(mode_q), {(ADDR_NBIT-8){1'b0}}};
                    ST_INS:  tx_q <= bit_last ? addr_q : {tx_q[ADDR_NBIT-2:0], 1'b0};
                    ST_ADDR: tx_q <= {tx_q[ADDR_NBIT-2:0], 1'b0};
                    default: ;
                endcase

                if (state_q == ST_DATA && bit_last) begin
                    rdata_q     <= rx_d;
                    rdv_q       <= 1'b1;
                    byte_left_q <= byte_left_q - 1'b1;
                end

                if (state_q == ST_CSHD) begin
                    rdone_q <= 1'b1;
                end
            end
        end
    end

    assign rbusy = (state_q != ST_IDLE);
    assign cs    = (state_q == ST_IDLE) || (state_q == ST_CSHD);
    assign sdo   = ((state_q == ST_INS) || (state_q == ST_ADDR)) ? tx_q[ADDR_NBIT-1] : 1'b0;
    assign rdata = rdata_q;
    assign rdv   = rdv_q;
    assign rdone = rdone_q;
    assign wp    = 1'b1;
    assign hold  = 1'b1;

endmodule

// File: tb/tb_flash_burst_rd.sv
// -----------------------------------------------------------------------------
// tb_flash_burst_rd
// Bench for flash_burst_rd: one instance at SCLK_DIV=4 and one at SCLK_DIV=2,
// sharing a behavioural SPI flash model selected by 'sel'.
// -----------------------------------------------------------------------------
module tb_flash_burst_rd;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        rd   = 1'b0;
    logic        sel  = 1'b0;
    logic        sdi  = 1'b0;
    logic [1:0]  mode  = 2'b00;
    logic [23:0] raddr = '0;
    logic [7:0]  rlen  = '0;

    logic       rbusy4, rdv4, rdone4, sclk4, cs4, sdo4, wp4, hold4;
    logic       rbusy2, rdv2, rdone2, sclk2, cs2, sdo2, wp2, hold2;
    logic [7:0] rdata4, rdata2;
    logic       rd4, rd2;

    assign rd4 = rd && !sel;
    assign rd2 = rd && sel;

    always #5 mclk = ~mclk;

    flash_burst_rd #(.SCLK_DIV(4), .ADDR_NBIT(24), .LEN_NBIT(8)) dut4 (
        .mclk(mclk), .rst(rst), .rd(rd4), .mode(mode), .raddr(raddr), .rlen(rlen),
        .rbusy(rbusy4), .rdata(rdata4), .rdv(rdv4), .rdone(rdone4),
        .sclk(sclk4), .cs(cs4), .sdo(sdo4), .sdi(sdi), .wp(wp4), .hold(hold4));

    flash_burst_rd #(.SCLK_DIV(2), .ADDR_NBIT(24), .LEN_NBIT(8)) dut2 (
        .mclk(mclk), .rst(rst), .rd(rd2), .mode(mode), .raddr(raddr), .rlen(rlen),
        .rbusy(rbusy2), .rdata(rdata2), .rdv(rdv2), .rdone(rdone2),
        .sclk(sclk2), .cs(cs2), .sdo(sdo2), .sdi(sdi), .wp(wp2), .hold(hold2));

    logic       sclk_m, cs_m, sdo_m, rdv_m, rdone_m, rbusy_m;
    logic [7:0] rdata_m;
    assign sclk_m  = sel ? sclk2  : sclk4;
    assign cs_m    = sel ? cs2    : cs4;
    assign sdo_m   = sel ? sdo2   : sdo4;
    assign rdv_m   = sel ? rdv2   : rdv4;
    assign rdone_m = sel ? rdone2 : rdone4;
    assign rbusy_m = sel ? rbusy2 : rbusy4;
    assign rdata_m = sel ? rdata2 : rdata4;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- flash model ----------------
    int          model_hdr    = 32;
    int          model_nbytes = 1;
    logic [7:0]  model_bytes [0:255];
    int          rise_cnt     = 0;
    logic [63:0] hdr_cap      = '0;
    int          sdo_data_bad = 0;

    always @(negedge cs_m) begin
        rise_cnt = 0;
        hdr_cap  = '0;
    end

    always @(posedge sclk_m) begin
        if (!cs_m) begin
            if (rise_cnt < model_hdr) hdr_cap = {hdr_cap[62:0], sdo_m};
            else if (sdo_m) sdo_data_bad++;
            rise_cnt++;
        end
    end

    always @(negedge sclk_m) begin
        if (!cs_m && rise_cnt >= model_hdr) begin
            int k;
            k = rise_cnt - model_hdr;
            if (k < 8 * model_nbytes) sdi = model_bytes[k / 8][7 - (k % 8)];
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          rdv_n = 0;
    logic [7:0]  rdv_data [0:299];
    int          rdv_cyc  [0:299];
    int          rdone_n = 0, rdone_cyc = 0;
    int          busy_run = 0, last_busy = 0;
    int          cs_run = 0, last_cs_gap = 0;
    int          sclk_bad = 0;
    logic [63:0] last_hdr = '0;
    int          last_rises = 0;

    always @(posedge mclk) cyc++;

    always @(negedge mclk) begin
        if (rdv_m) begin
            if (rdv_n < 300) begin
                rdv_data[rdv_n] = rdata_m;
                rdv_cyc[rdv_n]  = cyc;
            end
            rdv_n++;
        end
        if (rdone_m) begin
            rdone_n++;
            rdone_cyc  = cyc;
            last_hdr   = hdr_cap;
            last_rises = rise_cnt;
        end
        if (rbusy_m) busy_run++;
        else begin
            if (busy_run > 0) last_busy = busy_run;
            busy_run = 0;
        end
        if (cs_m) cs_run++;
        else begin
            if (cs_run > 0) last_cs_gap = cs_run;
            cs_run = 0;
        end
        if (cs_m && sclk_m) sclk_bad++;
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [23:0] addr;
        logic [7:0]  len;
        int          hdr_bits;
        logic [63:0] hdr;
        logic [31:0] data;   // byte 0 in [31:24]
        int          busy;
    } vec_t;

    vec_t vecs [4];

    task automatic load_model(input vec_t v);
        model_hdr    = v.hdr_bits;
        model_nbytes = int'(v.len) + 1;
        for (int i = 0; i < model_nbytes; i++) model_bytes[i] = v.data[31 - 8*i -: 8];
    endtask

    task automatic start(input logic [1:0] m, input logic [23:0] a, input logic [7:0] l);
        @(negedge mclk);
        rd = 1'b1; mode = m; raddr = a; rlen = l;
        @(negedge mclk);
        rd = 1'b0; mode = 2'b10; raddr = ~a; rlen = ~l;
    endtask

    task automatic wait_done(input int limit);
        int base;
        int k;
        base = rdone_n;
        k = 0;
        while (rdone_n == base && k < limit) begin
            @(negedge mclk); #1;
            k++;
        end
        if (rdone_n == base) begin
            n_checks++;
            n_fail++;
            $display("FAIL rdone_timeout: no rdone within %0d cycles", limit);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nb;
        nb = int'(v.len) + 1;
        load_model(v);
        rdv_n = 0;
        start(v.mode, v.addr, v.len);
        wait_done(2000);
        check($sformatf("v%0d_header", idx), last_hdr, v.hdr);
        check($sformatf("v%0d_sclk_rises", idx), 64'(last_rises), 64'(v.hdr_bits + 8*nb));
        check($sformatf("v%0d_rdv_count", idx), 64'(rdv_n), 64'(nb));
        for (int i = 0; i < nb && i < rdv_n; i++) begin
            check($sformatf("v%0d_byte%0d", idx, i), 64'(rdv_data[i]), 64'(v.data[31 - 8*i -: 8]));
            if (i > 0)
                check($sformatf("v%0d_rdv_spacing%0d", idx, i), 64'(rdv_cyc[i] - rdv_cyc[i-1]), 64'd32);
        end
        if (rdv_n >= 1)
            check($sformatf("v%0d_rdv_to_rdone", idx), 64'(rdone_cyc - rdv_cyc[nb-1]), 64'd4);
        check($sformatf("v%0d_busy_cycles", idx), 64'(last_busy), 64'(v.busy));
    endtask

    // ---------------- test ----------------
    initial begin
        //          mode   addr        len   hdr  header               data          busy
        vecs[0] = '{2'b00, 24'h012345, 8'd0, 32, 64'h03012345,        32'hA5000000, 4*(2+8+24+8)};
        vecs[1] = '{2'b01, 24'h100200, 8'd3, 40, 64'h0B1002_0000,     32'h11223344, 4*(2+8+24+8+32)};
        vecs[2] = '{2'b10, 24'h777777, 8'd2,  8, 64'h9F,              32'hEF401800, 4*(2+8+24)};
        vecs[3] = '{2'b11, 24'hFFFFFF, 8'd1, 32, 64'h03FFFFFF,        32'h5AC30000, 4*(2+8+24+16)};

        repeat (3) @(negedge mclk);
        #1;
        check("reset_pins_div4", {cs4, sclk4, sdo4, rbusy4, rdv4, rdone4, wp4, hold4}, 8'b1000_0011);
        check("reset_pins_div2", {cs2, sclk2, sdo2, rbusy2, rdv2, rdone2, wp2, hold2}, 8'b1000_0011);
        check("reset_rdata", {rdata4, rdata2}, 16'h0000);
        @(negedge mclk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) run_vec(v, vecs[v]);

        // rd pulse while busy is ignored; rd held high across rdone restarts
        load_model(vecs[0]);
        rdv_n = 0;
        start(2'b00, 24'h012345, 8'd0);
        repeat (15) @(negedge mclk);
        rd = 1'b1; mode = 2'b10; raddr = 24'h000000;
        @(negedge mclk);
        rd = 1'b0;
        repeat (100) @(negedge mclk);
        #1;
        rd = 1'b1; mode = 2'b00; raddr = 24'h012345; rlen = 8'd0;
        wait_done(400);
        check("b2b_first_busy", 64'(last_busy), 64'd168);
        check("b2b_first_header", last_hdr, 64'h03012345);
        @(negedge mclk); #1;
        rd = 1'b0; mode = 2'b10; raddr = 24'hFFFFFF; rlen = 8'hFF;
        check("b2b_restart_busy", 64'(rbusy4), 64'd1);
        wait_done(400);
        check("b2b_cs_gap", 64'(last_cs_gap), 64'd5);
        check("b2b_rdv_count", 64'(rdv_n), 64'd2);
        check("b2b_second_byte", 64'(rdv_data[1]), 64'hA5);
        check("b2b_second_busy", 64'(last_busy), 64'd168);

        // asynchronous reset in the middle of the address phase
        begin
            int base;
            load_model(vecs[0]);
            start(2'b00, 24'h012345, 8'd0);
            repeat (60) @(negedge mclk);
            #2;
            rst = 1'b1;
            #1;
            check("abort_pins", {cs4, sclk4, sdo4, rbusy4, rdv4, rdone4}, 6'b100000);
            check("abort_rdata", 64'(rdata4), 64'h00);
            base = rdone_n;
            @(negedge mclk);
            rst = 1'b0;
            repeat (30) @(negedge mclk);
            check("abort_no_rdone", 64'(rdone_n - base), 64'd0);
            run_vec(4, vecs[0]);
        end

        // SCLK_DIV=2, 256-byte burst
        @(negedge mclk);
        sel = 1'b1;
        model_hdr    = 32;
        model_nbytes = 256;
        for (int i = 0; i < 256; i++) model_bytes[i] = 8'((i * 37 + 5) & 255);
        rdv_n = 0;
        start(2'b00, 24'h000000, 8'hFF);
        wait_done(6000);
        check("div2_rdv_count", 64'(rdv_n), 64'd256);
        for (int i = 0; i < 256 && i < rdv_n; i++)
            check($sformatf("div2_byte%0d", i), 64'(rdv_data[i]), 64'((i * 37 + 5) & 255));
        check("div2_header", last_hdr, 64'h03000000);
        check("div2_busy_cycles", 64'(last_busy), 64'(2 * (2 + 8 + 24 + 2048)));
        if (rdv_n >= 256) begin
            check("div2_rdv_spacing", 64'(rdv_cyc[255] - rdv_cyc[254]), 64'd16);
            check("div2_rdv_to_rdone", 64'(rdone_cyc - rdv_cyc[255]), 64'd2);
        end

        check("sclk_high_while_cs_high", 64'(sclk_bad), 64'd0);
        check("sdo_nonzero_in_data", 64'(sdo_data_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
